// File: rtl/fft_pkg.sv
// Shared FFT constants and types used by the spectral post-processing blocks.
package fft_pkg;

    localparam int unsigned FFT_N    = 1024;
    localparam int unsigned FFT_W    = 16;
    localparam int unsigned FFT_LOGN = $clog2(FFT_N);

    typedef logic [2*FFT_W-1:0] fft_mag_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pf_state_e;

endpackage

// File: rtl/cplx_mag2.sv
// Two-stage registered squared magnitude (re^2 + im^2) with valid passthrough.
module cplx_mag2 import fft_pkg::*; #(
    parameter int unsigned W = FFT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    output logic [2*W-1:0]      out_mag
);

    localparam int unsigned MW = 2 * W;

    logic signed [MW-1:0] re_ext;
    logic signed [MW-1:0] im_ext;
    logic [MW-1:0]        re_sq;
    logic [MW-1:0]        im_sq;
    logic                 sq_valid;

    assign re_ext = MW'(in_re);
    assign im_ext = MW'(in_im);

    // Squares are non-negative and at most 2^(2W-2), so the sum fits in 2W unsigned bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_valid  <= 1'b0;
            re_sq     <= '0;
            im_sq     <= '0;
            out_valid <= 1'b0;
            out_mag   <= '0;
        end else begin
            sq_valid  <= in_valid;
            out_valid <= sq_valid;
            if (in_valid) begin
                re_sq <= $unsigned(re_ext * re_ext);
                im_sq <= $unsigned(im_ext * im_ext);
            end
            if (sq_valid) begin
                out_mag <= re_sq + im_sq;
            end
        end
    end

endmodule

// File: rtl/fft_peak_finder.sv
// Streaming per-frame peak detector on the FFT output: reports index and
// squared magnitude of the largest candidate bin once per N-bin frame.
module fft_peak_finder import fft_pkg::*; #(
    parameter int unsigned N           = FFT_N,
    parameter int unsigned W           = FFT_W,
    parameter bit          SEARCH_HALF = 1'b1,
    parameter bit          SKIP_DC     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic signed [W-1:0]    in_re,
    input  logic signed [W-1:0]    in_im,
    output logic                   peak_valid,
    output logic [$clog2(N)-1:0]   peak_bin,
    output logic [2*W-1:0]         peak_mag,
    output logic                   frame_err
);

    localparam int unsigned LOGN = $clog2(N);
    localparam int unsigned MW   = 2 * W;
    localparam logic [LOGN-1:0] LAST_BIN = LOGN'(N - 1);

    pf_state_e       state;
    logic [LOGN-1:0] cnt;
    logic            seen;

    logic            accept;
    logic            early_sop;
    logic            cand;
    logic            first;
    logic [LOGN-1:0] bin;

    assign accept    = in_valid & (in_sop | (state == ST_RUN));
    assign bin       = in_sop ? '0 : cnt;
    assign early_sop = in_valid & in_sop & (state == ST_RUN) & (cnt != '0);
    assign cand      = (!SEARCH_HALF || !bin[LOGN-1]) && !(SKIP_DC && (bin == '0));
    assign first     = cand & (in_sop | ~seen);

    // Frame control: bin counter, state, and "candidate already seen" flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            seen      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= early_sop;
            if (accept) begin
                seen <= (seen & ~in_sop) | cand;
                if (bin == LAST_BIN) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else begin
                    state <= ST_RUN;
                    cnt   <= bin + LOGN'(1);
                end
            end
        end
    end

    logic            mag_valid;
    logic [MW-1:0]   mag;

    cplx_mag2 #(.W(W)) u_mag (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (mag_valid),
        .out_mag   (mag)
    );

    logic            s0_valid;
    logic [LOGN-1:0] s0_bin;
    logic            s0_cand;
    logic            s0_first;
    logic            s0_last;
    logic [LOGN-1:0] s1_bin;
    logic            s1_cand;
    logic            s1_first;
    logic            s1_last;

    // Tags travel alongside the magnitude pipeline so frames never mix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_bin   <= '0;
            s0_cand  <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            s1_bin   <= '0;
            s1_cand  <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_bin   <= bin;
                s0_cand  <= cand;
                s0_first <= first;
                s0_last  <= (bin == LAST_BIN);
            end
            if (s0_valid) begin
                s1_bin   <= s0_bin;
                s1_cand  <= s0_cand;
                s1_first <= s0_first;
                s1_last  <= s0_last;
            end
        end
    end

    logic [MW-1:0]   run_mag;
    logic [LOGN-1:0] run_bin;
    logic            upd;
    logic [MW-1:0]   nxt_mag;
    logic [LOGN-1:0] nxt_bin;

    assign upd     = mag_valid & s1_cand & (s1_first | (mag > run_mag));
    assign nxt_mag = upd ? mag : run_mag;
    assign nxt_bin = upd ? s1_bin : run_bin;

    // Running max; strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_mag    <= '0;
            run_bin    <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
        end else begin
            peak_valid <= mag_valid & s1_last;
            if (mag_valid) begin
                run_mag <= nxt_mag;
                run_bin <= nxt_bin;
            end
            if (mag_valid & s1_last) begin
                peak_mag <= nxt_mag;
                peak_bin <= nxt_bin;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Scoreboard bench: three peak finders (default, SKIP_DC=0, SEARCH_HALF=0) share one stimulus stream.
module tb_fft_peak_finder;
    import fft_pkg::*;

    localparam int unsigned N    = FFT_N;
    localparam int unsigned LOGN = FFT_LOGN;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_sop = 1'b0;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;

    logic              pv [3];
    logic [LOGN-1:0]   pb [3];
    fft_mag_t          pm [3];
    logic              fe [3];

    fft_peak_finder dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_re(in_re), .in_im(in_im),
        .peak_valid(pv[0]), .peak_bin(pb[0]), .peak_mag(pm[0]), .frame_err(fe[0]));

    fft_peak_finder #(.SKIP_DC(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_re(in_re), .in_im(in_im),
        .peak_valid(pv[1]), .peak_bin(pb[1]), .peak_mag(pm[1]), .frame_err(fe[1]));

    fft_peak_finder #(.SEARCH_HALF(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_re(in_re), .in_im(in_im),
        .peak_valid(pv[2]), .peak_bin(pb[2]), .peak_mag(pm[2]), .frame_err(fe[2]));

    always #5 clk = ~clk;

    typedef struct {
        int     bin;
        longint mag;
        int     cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int ferr_cnt [3] = '{0, 0, 0};

    logic signed [15:0] re_mem [N];
    logic signed [15:0] im_mem [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < int'(N); i++) begin
            re_mem[i] = '0;
            im_mem[i] = '0;
        end
    endtask

    task automatic set_bin(input int b, input int re, input int im);
        re_mem[b] = 16'(re);
        im_mem[b] = 16'(im);
    endtask

    task automatic push_exp(input int d, input int b, input longint m, input int c);
        exp_t e;
        e.bin = b;
        e.mag = m;
        e.cyc = c;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Sends bins 0..nbins-1; gap idle cycles between samples (none after the last).
    task automatic send(input int nbins, input int gap,
                        input int b0, input longint m0,
                        input int b1, input longint m1,
                        input int b2, input longint m2);
        for (int b = 0; b < nbins; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sop   = (b == 0);
            in_re    = re_mem[b];
            in_im    = im_mem[b];
            if (b == int'(N) - 1) begin
                push_exp(0, b0, m0, cyc + 3);
                push_exp(1, b1, m1, cyc + 3);
                push_exp(2, b2, m2, cyc + 3);
            end
            if (b != nbins - 1) begin
                repeat (gap) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_sop   = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sop   = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_dut%0d_peak_valid", tag, d), longint'(pv[d]), 0);
            check($sformatf("%s_dut%0d_peak_bin", tag, d), longint'(pb[d]), 0);
            check($sformatf("%s_dut%0d_peak_mag", tag, d), longint'(pm[d]), 0);
            check($sformatf("%s_dut%0d_frame_err", tag, d), longint'(fe[d]), 0);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a peak.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                exp_t e;
                logic have;
                have = 1'b0;
                e.bin = 0;
                e.mag = 0;
                e.cyc = 0;
                if (fe[d]) ferr_cnt[d]++;
                if (pv[d]) begin
                    case (d)
                        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                    endcase
                    if (!have) begin
                        check($sformatf("dut%0d_unexpected_peak_valid", d), longint'(pv[d]), 0);
                    end else begin
                        check($sformatf("dut%0d_peak_bin", d), longint'(pb[d]), longint'(e.bin));
                        check($sformatf("dut%0d_peak_mag", d), longint'(pm[d]), e.mag);
                        check($sformatf("dut%0d_peak_cycle", d), longint'(cyc), longint'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        #1 check_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Single tone with mirror image; ties resolve to the low bin in full search.
        clear_mem();
        set_bin(10, 1000, 0);
        set_bin(1014, 1000, 0);
        send(1024, 0, 10, 1000000, 10, 1000000, 10, 1000000);
        idle(6);

        // Full-scale negative corner at DC and bin 5.
        clear_mem();
        set_bin(0, -32768, -32768);
        set_bin(5, -32768, -32768);
        send(1024, 0, 5, 64'd2147483648, 0, 64'd2147483648, 5, 64'd2147483648);
        idle(6);

        // Ties and search range.
        clear_mem();
        set_bin(7, 0, 200);
        set_bin(300, 0, 200);
        set_bin(600, 0, 500);
        send(1024, 0, 7, 40000, 7, 40000, 600, 250000);
        idle(6);

        // Gapped frame A then back-to-back continuous frame B with a smaller peak.
        clear_mem();
        set_bin(20, 300, 400);
        send(1024, 10, 20, 250000, 20, 250000, 20, 250000);
        clear_mem();
        set_bin(30, 30, 40);
        send(1024, 0, 30, 2500, 30, 2500, 30, 2500);
        idle(6);

        // Early sop at bin 500: the aborted frame's large bin must not leak.
        clear_mem();
        set_bin(100, 0, 700);
        send(500, 0, 0, 0, 0, 0, 0, 0);
        clear_mem();
        set_bin(0, 10, 0);
        set_bin(200, 50, 0);
        send(1024, 0, 200, 2500, 200, 2500, 200, 2500);
        idle(6);

        // Reset mid-frame at bin 700: outputs clear asynchronously.
        clear_mem();
        set_bin(50, 900, 0);
        send(700, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        clear_mem();
        set_bin(77, 0, -1234);
        send(1024, 0, 77, 1522756, 77, 1522756, 77, 1522756);
        idle(10);

        check("dut0_missing_peaks", longint'(q0.size()), 0);
        check("dut1_missing_peaks", longint'(q1.size()), 0);
        check("dut2_missing_peaks", longint'(q2.size()), 0);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d_frame_err_count", d), longint'(ferr_cnt[d]), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
